// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined immediate generator with a 2-entry skid buffer, illegal flag and error counter
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic [CNT_W-1:0] err_count
);
  logic [31:7] i;
  logic [31:0] raw;
  logic sx, ill;
  logic [XLEN-1:0] imm;
  assign i = in_instr;
  // Formats are first assembled as 32-bit values; sign formats then extend from bit 31 to XLEN.
  always_comb begin
    raw = '0;
    sx = 1'b1;
    ill = 1'b0;
    case (in_imm_src)
      3'd0: raw = {{20{i[31]}}, i[31:20]};
      3'd1: raw = {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2: raw = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3: raw = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      3'd4: raw = {i[31:12], 12'b0};
      3'd5: begin
        raw = {27'b0, i[19:15]};
        sx = 1'b0;
      end
      3'd6: begin
        raw = XLEN == 64 ? {26'b0, i[25:20]} : {27'b0, i[24:20]};
        sx = 1'b0;
        ill = XLEN != 64 && i[25];
      end
      default: ill = 1'b1;
    endcase
    imm = ill ? '0 : sx ? XLEN'($signed(raw)) : XLEN'(raw);
  end
  logic             out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  out_imm_q, out_imm_d, skid_imm_q, skid_imm_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d, skid_tag_q, skid_tag_d;
  logic             out_ill_q, out_ill_d, skid_ill_q, skid_ill_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic accept, consume, load_out, load_skid;
  always_comb begin
    accept = in_valid && !skid_valid_q;
    consume = out_valid_q && out_ready;
    load_out = skid_valid_q ? consume : accept && (!out_valid_q || consume);
    load_skid = accept && out_valid_q && !consume;
    out_valid_d = skid_valid_q || (out_valid_q && !consume) || accept;
    skid_valid_d = skid_valid_q ? !consume : load_skid;
    out_imm_d = !load_out ? out_imm_q : skid_valid_q ? skid_imm_q : imm;
    out_tag_d = !load_out ? out_tag_q : skid_valid_q ? skid_tag_q : in_tag;
    out_ill_d = !load_out ? out_ill_q : skid_valid_q ? skid_ill_q : ill;
    skid_imm_d = load_skid ? imm : skid_imm_q;
    skid_tag_d = load_skid ? in_tag : skid_tag_q;
    skid_ill_d = load_skid ? ill : skid_ill_q;
    err_d = accept && ill && err_q != '1 ? err_q + 1'b1 : err_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      out_imm_q <= '0;
      out_tag_q <= '0;
      out_ill_q <= 1'b0;
      skid_imm_q <= '0;
      skid_tag_q <= '0;
      skid_ill_q <= 1'b0;
      err_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_imm_q <= out_imm_d;
      out_tag_q <= out_tag_d;
      out_ill_q <= out_ill_d;
      skid_imm_q <= skid_imm_d;
      skid_tag_q <= skid_tag_d;
      skid_ill_q <= skid_ill_d;
      err_q <= err_d;
    end
  end
  assign in_ready = !skid_valid_q;
  assign out_valid = out_valid_q;
  assign out_imm = out_imm_q;
  assign out_tag = out_tag_q;
  assign out_illegal = out_ill_q;
  assign err_count = err_q;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: scoreboard bench driving an XLEN=32/CNT_W=8 and an XLEN=64/CNT_W=2 instance in lockstep
module tb_imm_gen_pipe;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [24:0] in_instr = '0;
  logic [2:0] in_imm_src = '0;
  logic [7:0] in_tag = '0;
  logic a_in_ready, a_out_valid, a_ill, b_in_ready, b_out_valid, b_ill;
  logic [31:0] a_imm;
  logic [63:0] b_imm;
  logic [7:0] a_tag, b_tag, a_err;
  logic [1:0] b_err;
  always #5 clk = ~clk;
  imm_gen_pipe #(.XLEN(32), .TAG_W(8), .CNT_W(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_imm(a_imm),
    .out_tag(a_tag), .out_illegal(a_ill), .err_count(a_err));
  imm_gen_pipe #(.XLEN(64), .TAG_W(8), .CNT_W(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_imm(b_imm),
    .out_tag(b_tag), .out_illegal(b_ill), .err_count(b_err));
  typedef struct {
    logic [31:0] ia;
    logic [63:0] ib;
    logic [7:0]  tag;
    logic        la;
    logic        lb;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int n_acc = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask
  function automatic void model(input logic [31:0] i, input logic [2:0] s, input int xl,
                                output logic [63:0] v, output logic ill);
    ill = 1'b0;
    v = '0;
    case (s)
      3'd0: v = {{52{i[31]}}, i[31:20]};
      3'd1: v = {{52{i[31]}}, i[31:25], i[11:7]};
      3'd2: v = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3: v = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      3'd4: v = {{32{i[31]}}, i[31:12], 12'b0};
      3'd5: v = {59'b0, i[19:15]};
      3'd6: if (xl == 64) v = {58'b0, i[25:20]};
            else if (i[25]) ill = 1'b1;
            else v = {59'b0, i[24:20]};
      default: ill = 1'b1;
    endcase
  endfunction
  logic pv = 1'b0, pr = 1'b0;
  logic [31:0] pimm;
  logic [7:0] ptag;
  always @(negedge clk) begin
    if (reset_n) begin
      if (pv && !pr && a_out_valid) begin
        chk("stall_imm", 64'(a_imm), 64'(pimm));
        chk("stall_tag", 64'(a_tag), 64'(ptag));
      end
      if (a_out_valid && out_ready) begin
        if (q.size() == 0) chk("sb_empty", 64'(q.size()), 64'd1);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("imm32", 64'(a_imm), 64'(e.ia));
          chk("tag32", 64'(a_tag), 64'(e.tag));
          chk("ill32", 64'(a_ill), 64'(e.la));
          chk("valid64", 64'(b_out_valid), 64'd1);
          chk("imm64", b_imm, e.ib);
          chk("tag64", 64'(b_tag), 64'(e.tag));
          chk("ill64", 64'(b_ill), 64'(e.lb));
        end
      end
      if (in_valid && a_in_ready) begin
        exp_t e;
        logic [63:0] v;
        model({in_instr, 7'b0}, in_imm_src, 32, v, e.la);
        e.ia = v[31:0];
        model({in_instr, 7'b0}, in_imm_src, 64, e.ib, e.lb);
        e.tag = in_tag;
        q.push_back(e);
        n_acc++;
      end
      pv = a_out_valid;
      pr = out_ready;
      pimm = a_imm;
      ptag = a_tag;
    end else pv = 1'b0;
  end
  task automatic send(input logic [31:0] ins, input logic [2:0] s, input logic [7:0] t, output int cyc);
    logic ok;
    cyc = 0;
    in_valid = 1'b1;
    in_instr = ins[31:7];
    in_imm_src = s;
    in_tag = t;
    do begin
      @(negedge clk);
      ok = a_in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end while (!ok && cyc < 50);
    chk("accept", 64'(ok), 64'd1);
    in_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    int c, base;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_valid", 64'(a_out_valid), 64'd0);
    chk("rst_in_ready", 64'(a_in_ready), 64'd1);
    chk("rst_imm", 64'(a_imm), 64'd0);
    chk("rst_tag", 64'(a_tag), 64'd0);
    chk("rst_ill", 64'(a_ill), 64'd0);
    chk("rst_err", 64'(a_err), 64'd0);
    idle(2);
    reset_n = 1'b1;
    out_ready = 1'b1;
    send(32'hFFF00093, 3'd0, 8'h10, c);
    chk("i_lat", 64'(c), 64'd1);
    chk("i_imm", 64'(a_imm), 64'hFFFFFFFF);
    send(32'hFE000EE3, 3'd2, 8'h11, c);
    chk("b_b2b", 64'(c), 64'd1);
    chk("b_valid", 64'(a_out_valid), 64'd1);
    chk("b_imm", 64'(a_imm), 64'hFFFFFFFC);
    send(32'h123450B7, 3'd4, 8'h12, c);
    chk("u_b2b", 64'(c), 64'd1);
    chk("u_imm", 64'(a_imm), 64'h12345000);
    chk("u_imm64", b_imm, 64'h12345000);
    send(32'h0080006F, 3'd3, 8'h13, c);
    chk("j_b2b", 64'(c), 64'd1);
    chk("j_imm", 64'(a_imm), 64'h8);
    idle(1);
    out_ready = 1'b0;
    send(32'h00500093, 3'd0, 8'd1, c);
    send(32'h00600093, 3'd0, 8'd2, c);
    chk("bp_in_ready", 64'(a_in_ready), 64'd0);
    in_valid = 1'b1;
    in_instr = 25'(32'h00700093 >> 7);
    in_tag = 8'd3;
    idle(3);
    chk("bp_hold_ready", 64'(a_in_ready), 64'd0);
    chk("bp_hold_valid", 64'(a_out_valid), 64'd1);
    chk("bp_hold_tag", 64'(a_tag), 64'd1);
    chk("bp_hold_imm", 64'(a_imm), 64'd5);
    chk("bp_q_depth", 64'(q.size()), 64'd2);
    out_ready = 1'b1;
    send(32'h00700093, 3'd0, 8'd3, c);
    chk("bp_resume_cyc", 64'(c), 64'd2);
    idle(3);
    chk("bp_drained", 64'(q.size()), 64'd0);
    send(32'h0, 3'd7, 8'h20, c);
    chk("ill_flag", 64'(a_ill), 64'd1);
    chk("ill_imm", 64'(a_imm), 64'd0);
    chk("ill_err", 64'(a_err), 64'd1);
    chk("ill_err64", 64'(b_err), 64'd1);
    send(32'h02000000, 3'd6, 8'h21, c);
    chk("sh32_ill", 64'(a_ill), 64'd1);
    chk("sh32_err", 64'(a_err), 64'd2);
    chk("sh64_legal", 64'(b_ill), 64'd0);
    chk("sh64_imm", b_imm, 64'd32);
    chk("sh64_err", 64'(b_err), 64'd1);
    for (int k = 0; k < 4; k++) send(32'hFFFFFFFF, 3'd7, 8'(8'h22 + k), c);
    chk("sat_err32", 64'(a_err), 64'd6);
    chk("sat_err64", 64'(b_err), 64'd3);
    send(32'h823450B7, 3'd4, 8'h30, c);
    chk("u64_imm", b_imm, 64'hFFFFFFFF82345000);
    chk("u64_imm32", 64'(a_imm), 64'h82345000);
    send(32'h03F00000, 3'd6, 8'h31, c);
    chk("sh63_imm", b_imm, 64'd63);
    chk("sh63_a_ill", 64'(a_ill), 64'd1);
    send(32'h000F8000, 3'd5, 8'h32, c);
    chk("zimm64", b_imm, 64'h1F);
    chk("zimm32", 64'(a_imm), 64'h1F);
    chk("err_after", 64'(a_err), 64'd7);
    idle(2);
    out_ready = 1'b0;
    send(32'h00100093, 3'd7, 8'h40, c);
    send(32'h00200093, 3'd0, 8'h41, c);
    chk("f2_in_ready", 64'(a_in_ready), 64'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", 64'(a_out_valid), 64'd0);
    chk("arst_in_ready", 64'(a_in_ready), 64'd1);
    chk("arst_err", 64'(a_err), 64'd0);
    chk("arst_err64", 64'(b_err), 64'd0);
    chk("arst_imm", 64'(a_imm), 64'd0);
    q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    send(32'hFFF00093, 3'd0, 8'h50, c);
    chk("post_rst_lat", 64'(c), 64'd1);
    chk("post_rst_valid", 64'(a_out_valid), 64'd1);
    chk("post_rst_imm", 64'(a_imm), 64'hFFFFFFFF);
    idle(2);
    base = n_acc;
    c = 0;
    while (n_acc - base < 10000 && c < 40000) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_instr = 25'($urandom);
      in_imm_src = 3'($urandom);
      in_tag = 8'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      idle(1);
      c++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    c = 0;
    while (q.size() != 0 && c < 10) begin
      idle(1);
      c++;
    end
    chk("stress_count", 64'(n_acc - base), 64'd10000);
    chk("stress_drain", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
